// File: rtl/sdram_port_arbiter.sv
// Serialises NUM_PORTS toggle-handshake clients onto one SDRAM controller read/write port.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (port 0 highest).
module sdram_port_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 25
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        c_req,
  output logic [NUM_PORTS-1:0]        c_ack,
  input  logic [NUM_PORTS-1:0]        c_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] c_addr,
  input  logic [NUM_PORTS*16-1:0]     c_din,
  output logic [NUM_PORTS*8-1:0]      c_dout,
  output logic [ADDR_W-1:0]           mem_raddr,
  output logic                        mem_rd,
  input  logic                        mem_rd_rdy,
  input  logic [7:0]                  mem_dout,
  output logic [ADDR_W-1:0]           mem_waddr,
  output logic [15:0]                 mem_din,
  output logic                        mem_we,
  input  logic                        mem_we_ack,
  output logic                        busy,
  output logic [1:0]                  grant_id
);

  typedef enum logic [1:0] {IDLE, RD_ACC, RD_DATA, WR_WAIT} state_t;

  state_t               state;
  logic [NUM_PORTS-1:0] pending;
  logic [1:0]           win;
  logic                 win_valid;
  logic                 can_grant;

  assign pending   = c_req ^ c_ack;
  assign can_grant = win_valid && mem_rd_rdy && (mem_we == mem_we_ack);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr;
  logic [1:0] hi_win, lo_win;
  logic       hi_valid;

  // Two-pass search: first pending port at or above rr_ptr, else lowest pending port.
  always_comb begin
    hi_win    = '0;
    lo_win    = '0;
    hi_valid  = 1'b0;
    win_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pending[i]) begin
        if (!win_valid) begin
          win_valid = 1'b1;
          lo_win    = 2'(i);
        end
        if (!hi_valid && i >= 32'(rr_ptr)) begin
          hi_valid = 1'b1;
          hi_win   = 2'(i);
        end
      end
    end
    win = hi_valid ? hi_win : lo_win;
  end
`else
  always_comb begin
    win       = '0;
    win_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (pending[i] && !win_valid) begin
        win_valid = 1'b1;
        win       = 2'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      c_ack     <= '0;
      c_dout    <= '0;
      mem_raddr <= '0;
      mem_rd    <= 1'b0;
      mem_waddr <= '0;
      mem_din   <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (can_grant) begin
            grant_id <= win;
            busy     <= 1'b1;
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            rr_ptr   <= (win == 2'(NUM_PORTS - 1)) ? '0 : win + 2'd1;
`endif
            if (c_we[win]) begin
              mem_waddr <= c_addr[win*ADDR_W +: ADDR_W];
              mem_din   <= c_din[win*16 +: 16];
              mem_we    <= ~mem_we;
              state     <= WR_WAIT;
            end else begin
              mem_raddr <= c_addr[win*ADDR_W +: ADDR_W];
              mem_rd    <= 1'b1;
              state     <= RD_ACC;
            end
          end
        end
        RD_ACC: begin
          // Drop rd once accepted so the controller does not re-issue at its next idle slot.
          if (!mem_rd_rdy) begin
            mem_rd <= 1'b0;
            state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (mem_rd_rdy) begin
            c_dout[grant_id*8 +: 8] <= mem_dout;
            c_ack[grant_id]         <= ~c_ack[grant_id];
            busy                    <= 1'b0;
            state                   <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mem_we_ack == mem_we) begin
            c_ack[grant_id] <= ~c_ack[grant_id];
            busy            <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small behavioural SDRAM controller model.
module tb_sdram_port_arbiter;
  localparam int NP = 3;
  localparam int AW = 25;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NP-1:0]    c_req, c_ack, c_we;
  logic [NP*AW-1:0] c_addr;
  logic [NP*16-1:0] c_din;
  logic [NP*8-1:0]  c_dout;
  logic [AW-1:0]    mem_raddr, mem_waddr;
  logic             mem_rd, mem_rd_rdy, mem_we, mem_we_ack, busy;
  logic [7:0]       mem_dout;
  logic [15:0]      mem_din;
  logic [1:0]       grant_id;

  logic             hold, init_pulse, model_rdy;
  int               rd_cnt, wcnt, rd_rises;
  logic [7:0]       rd_data;
  logic             busy_q, rd_q;
  logic [1:0]       gq[$];
  int               n_checks, n_pass, base;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .c_req(c_req), .c_ack(c_ack), .c_we(c_we), .c_addr(c_addr), .c_din(c_din), .c_dout(c_dout),
    .mem_raddr(mem_raddr), .mem_rd(mem_rd), .mem_rd_rdy(mem_rd_rdy), .mem_dout(mem_dout),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_we(mem_we), .mem_we_ack(mem_we_ack),
    .busy(busy), .grant_id(grant_id)
  );

  assign mem_rd_rdy = hold ? 1'b0 : model_rdy;

  // Controller model: rd_rdy falls 2 clk after rd, rises 4 clk later with addr[7:0]^0x79; we_ack echoes after 3 clk.
  always @(negedge clk) begin
    if (init_pulse) begin
      model_rdy  = 1'b1;
      mem_we_ack = 1'b0;
      rd_cnt     = 0;
      wcnt       = 0;
      mem_dout   = 8'h00;
    end else begin
      if (rd_cnt == 0) begin
        if (mem_rd && mem_rd_rdy) begin
          rd_cnt  = 1;
          rd_data = mem_raddr[7:0] ^ 8'h79;
        end
      end else begin
        rd_cnt++;
        if (rd_cnt == 3) model_rdy = 1'b0;
        if (rd_cnt == 7) begin
          mem_dout  = rd_data;
          model_rdy = 1'b1;
          rd_cnt    = 0;
        end
      end
      if (mem_we != mem_we_ack) begin
        wcnt++;
        if (wcnt == 3) begin
          mem_we_ack = mem_we;
          wcnt       = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (busy === 1'b1 && busy_q !== 1'b1) gq.push_back(grant_id);
    if (mem_rd === 1'b1 && rd_q !== 1'b1) rd_rises++;
    busy_q = busy;
    rd_q   = mem_rd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic request(input int p, input logic we, input logic [AW-1:0] a, input logic [15:0] d);
    c_we[p]            = we;
    c_addr[p*AW +: AW] = a;
    c_din[p*16 +: 16]  = d;
    c_req[p]           = ~c_req[p];
  endtask

  task automatic wait_ack(input int p, input string tag);
    for (int k = 0; k < 300 && c_ack[p] !== c_req[p]; k++) @(negedge clk);
    check(tag, 32'(c_ack[p]), 32'(c_req[p]));
  endtask

  task automatic do_reset(input logic with_init);
    reset_n    = 1'b0;
    c_req      = '0;
    init_pulse = with_init;
    repeat (3) @(negedge clk);
    reset_n    = 1'b1;
    init_pulse = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_pass = 0; rd_rises = 0;
    hold = 1'b0; model_rdy = 1'b1; mem_we_ack = 1'b0; mem_dout = 8'h00; rd_cnt = 0; wcnt = 0;
    c_req = '0; c_we = '0; c_addr = '0; c_din = '0;
    reset_n = 1'b0; init_pulse = 1'b1;
    #2;
    check("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    do_reset(1'b1);
    @(negedge clk);

    check("rst_c_ack", 32'(c_ack), 32'd0);
    check("rst_c_dout", 32'(c_dout), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);

    // Single read on port 1
    request(1, 1'b0, 25'h000123, 16'h0000);
    wait_ack(1, "rd_ack_wait");
    check("rd_raddr", 32'(mem_raddr), 32'h123);
    check("rd_dout1", 32'(c_dout[15:8]), 32'h5A);
    check("rd_c_ack", 32'(c_ack), 32'b010);
    check("rd_busy", 32'(busy), 32'd0);
    check("rd_mem_rd_low", 32'(mem_rd), 32'd0);
    check("rd_pulses", 32'(rd_rises), 32'd1);
    check("rd_grant", 32'(grant_id), 32'd1);

    // Single write on port 2
    request(2, 1'b1, 25'h1FFFFFE, 16'hBEEF);
    wait_ack(2, "wr_ack_wait");
    check("wr_waddr", 32'(mem_waddr), 32'h1FFFFFE);
    check("wr_din", 32'(mem_din), 32'hBEEF);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_c_ack", 32'(c_ack), 32'b110);
    check("wr_no_rd", 32'(rd_rises), 32'd1);
    check("wr_grant", 32'(grant_id), 32'd2);

    // Three simultaneous reads
    base = gq.size();
    request(0, 1'b0, 25'h010, 16'h0);
    request(1, 1'b0, 25'h020, 16'h0);
    request(2, 1'b0, 25'h030, 16'h0);
    wait_ack(0, "c3_ack0");
    wait_ack(1, "c3_ack1");
    wait_ack(2, "c3_ack2");
    check("c3_ngrants", 32'(gq.size() - base), 32'd3);
    if (gq.size() >= base + 3) begin
      check("c3_order0", 32'(gq[base]), 32'd0);
      check("c3_order1", 32'(gq[base+1]), 32'd1);
      check("c3_order2", 32'(gq[base+2]), 32'd2);
    end
    check("c3_dout", 32'(c_dout), 32'h49_59_69);

    // Port 0 re-requests right after its ack while port 2 waits
    base = gq.size();
    request(0, 1'b0, 25'h040, 16'h0);
    request(2, 1'b0, 25'h050, 16'h0);
    wait_ack(0, "rq_ack0a");
    request(0, 1'b0, 25'h060, 16'h0);
    wait_ack(2, "rq_ack2");
    wait_ack(0, "rq_ack0b");
    check("rq_ngrants", 32'(gq.size() - base), 32'd3);
    if (gq.size() >= base + 3) begin
      check("rq_order0", 32'(gq[base]), 32'd0);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      check("rq_order1", 32'(gq[base+1]), 32'd2);
      check("rq_order2", 32'(gq[base+2]), 32'd0);
`else
      check("rq_order1", 32'(gq[base+1]), 32'd0);
      check("rq_order2", 32'(gq[base+2]), 32'd2);
`endif
    end
    check("rq_dout0", 32'(c_dout[7:0]), 32'h19);
    check("rq_dout2", 32'(c_dout[23:16]), 32'h29);

    // Post-init hold-off: rd_rdy low after reset
    hold = 1'b1;
    do_reset(1'b1);
    @(negedge clk);
    check("ho_rst_dout", 32'(c_dout), 32'd0);
    base = rd_rises;
    request(0, 1'b0, 25'h0F0, 16'h0);
    repeat (10) @(negedge clk);
    check("ho_no_rd", 32'(mem_rd), 32'd0);
    check("ho_busy", 32'(busy), 32'd0);
    check("ho_no_pulse", 32'(rd_rises - base), 32'd0);
    hold = 1'b0;
    wait_ack(0, "ho_ack_wait");
    check("ho_dout", 32'(c_dout[7:0]), 32'h89);

    // Reset while in RD_DATA
    request(1, 1'b0, 25'h0AA, 16'h0);
    for (int k = 0; k < 50 && mem_rd !== 1'b1; k++) @(negedge clk);
    check("mr_rd_start", 32'(mem_rd), 32'd1);
    for (int k = 0; k < 50 && mem_rd !== 1'b0; k++) @(negedge clk);
    check("mr_rd_drop", 32'(mem_rd), 32'd0);
    check("mr_busy_pre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    c_req   = '0;
    #1;
    check("mr_async_ack", 32'(c_ack), 32'd0);
    check("mr_async_dout", 32'(c_dout), 32'd0);
    check("mr_async_busy", 32'(busy), 32'd0);
    check("mr_async_grant", 32'(grant_id), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mr_post_ack", 32'(c_ack), 32'd0);
    check("mr_post_dout", 32'(c_dout), 32'd0);
    check("mr_post_busy", 32'(busy), 32'd0);
    request(2, 1'b0, 25'h0AB, 16'h0);
    wait_ack(2, "mr_ack_wait");
    check("mr_new_dout", 32'(c_dout[23:16]), 32'hD2);
    check("mr_new_ack", 32'(c_ack), 32'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
